// File: rtl/ground_texel_fetch_if.sv
// Bus bundle for ground_texel_fetch.
//   in_*      : clipped ground sample from the ground-validity stage (in_en/in_ready)
//   map_*     : read port towards the synchronous maze map memory
//   out_*     : shaded texel towards the pixel writer (out_valid/out_ready)
//   drop_cnt  : saturating count of out-of-range samples
// slave  = the texel fetch block itself, master = its environment.
interface ground_texel_fetch_if;
  logic signed [9:0] in_x;
  logic signed [9:0] in_y;
  logic signed [9:0] in_z;
  logic signed [9:0] in_p;
  logic              in_en;
  logic              in_ready;
  logic [6:0]        map_addr;
  logic              map_rd;
  logic [3:0]        map_data;
  logic signed [9:0] out_p;
  logic [11:0]       out_color;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       drop_cnt;

  modport slave (
    input  in_x, in_y, in_z, in_p, in_en,
    output in_ready,
    output map_addr, map_rd,
    input  map_data,
    output out_p, out_color, out_valid,
    input  out_ready,
    output drop_cnt
  );

  modport master (
    output in_x, in_y, in_z, in_p, in_en,
    input  in_ready,
    input  map_addr, map_rd,
    output map_data,
    input  out_p, out_color, out_valid,
    output out_ready,
    input  drop_cnt
  );
endinterface

// File: rtl/ground_texel_fetch.sv
// Ground texel fetch: looks up the maze cell under a ground-plane sample and
// shades it (floor checker / wall base / exit), then queues {p, colour} in a
// small first-word-fall-through FIFO towards the pixel writer.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    ground_texel_fetch_if.slave (sample in, map read port, texel out,
//          drop counter)
// Pipeline: accept -> map read issued (stage 0) -> map data returns (stage 1)
// -> FIFO write. Upstream is throttled by credits so the FIFO never overflows.
module ground_texel_fetch #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [11:0] FLOOR_A    = 12'hAAA,
  parameter logic [11:0] FLOOR_B    = 12'h777,
  parameter logic [11:0] WALL_COLOR = 12'h642,
  parameter logic [11:0] EXIT_COLOR = 12'h0F0
) (
  input logic             clk,
  input logic             rst_n,
  ground_texel_fetch_if.slave bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  // registered state
  logic              up_q, up_d;
  logic              s0_v_q, s0_v_d;
  logic              s0_tx4_q, s0_tx4_d;
  logic              s0_ty4_q, s0_ty4_d;
  logic [9:0]        s0_p_q, s0_p_d;
  logic              s1_v_q, s1_v_d;
  logic              s1_tx4_q, s1_tx4_d;
  logic              s1_ty4_q, s1_ty4_d;
  logic [9:0]        s1_p_q, s1_p_d;
  logic [6:0]        map_addr_q, map_addr_d;
  logic              map_rd_q, map_rd_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [15:0]       drop_q, drop_d;
  logic [21:0]       fifo_mem_q [FIFO_DEPTH];

  // combinational helpers
  logic              in_range_s;
  logic [SW-1:0]     occ_s;
  logic              in_ready_s;
  logic              accept_ok_s;
  logic              drop_s;
  logic [6:0]        addr_s;
  logic [11:0]       colour_s;
  logic              push_s;
  logic              pop_s;
  logic              out_valid_s;
  logic [21:0]       head_s;
  logic              unused_s;

  // Only bit 4 of each texel offset matters for the checker; the rest and z
  // are deliberately ignored.
  assign unused_s = ^{bus.in_z, bus.in_x[3:0], bus.in_y[3:0]};

  // Input qualification, credit check and map address generation.
  always_comb begin
    in_range_s  = ~bus.in_x[9] && (bus.in_x[8:0] <= 9'd320) &&
                  ~bus.in_y[9] && (bus.in_y[8:0] <= 9'd320);
    // Every sample in the pipeline already owns a FIFO slot.
    occ_s       = SW'(count_q) + SW'(s0_v_q) + SW'(s1_v_q);
    in_ready_s  = up_q && (occ_s < SW'(FIFO_DEPTH));
    accept_ok_s = bus.in_en && in_ready_s && in_range_s;
    drop_s      = bus.in_en && in_ready_s && ~in_range_s;
    // Cells are 32 map units; the map is 11 cells wide, row-major.
    addr_s      = ({3'b000, bus.in_y[8:5]} * 7'd11) + {3'b000, bus.in_x[8:5]};
  end

  // Texel shading from the returned cell type.
  always_comb begin
    case (bus.map_data)
      4'h0:    colour_s = (s1_tx4_q ^ s1_ty4_q) ? FLOOR_A : FLOOR_B;
      4'hF:    colour_s = EXIT_COLOR;
      default: colour_s = WALL_COLOR;
    endcase
  end

  // FIFO handshake terms and head view.
  always_comb begin
    out_valid_s = (count_q != CW'(0));
    push_s      = s1_v_q;
    pop_s       = out_valid_s && bus.out_ready;
    head_s      = fifo_mem_q[rd_ptr_q];
  end

  // Next-state logic for pipeline, map port, FIFO bookkeeping and drop counter.
  always_comb begin
    up_d       = 1'b1;
    s0_v_d     = accept_ok_s;
    map_rd_d   = accept_ok_s;
    s1_v_d     = s0_v_q;
    s1_tx4_d   = s0_tx4_q;
    s1_ty4_d   = s0_ty4_q;
    s1_p_d     = s0_p_q;
    if (accept_ok_s) begin
      map_addr_d = addr_s;
      s0_tx4_d   = bus.in_x[4];
      s0_ty4_d   = bus.in_y[4];
      s0_p_d     = bus.in_p;
    end else begin
      map_addr_d = map_addr_q;
      s0_tx4_d   = s0_tx4_q;
      s0_ty4_d   = s0_ty4_q;
      s0_p_d     = s0_p_q;
    end

    if (drop_s && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end else begin
      drop_d = drop_q;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; up_q holds off in_ready until the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q       <= 1'b0;
      s0_v_q     <= 1'b0;
      s0_tx4_q   <= 1'b0;
      s0_ty4_q   <= 1'b0;
      s0_p_q     <= 10'd0;
      s1_v_q     <= 1'b0;
      s1_tx4_q   <= 1'b0;
      s1_ty4_q   <= 1'b0;
      s1_p_q     <= 10'd0;
      map_addr_q <= 7'd0;
      map_rd_q   <= 1'b0;
      wr_ptr_q   <= PW'(0);
      rd_ptr_q   <= PW'(0);
      count_q    <= CW'(0);
      drop_q     <= 16'd0;
    end else begin
      up_q       <= up_d;
      s0_v_q     <= s0_v_d;
      s0_tx4_q   <= s0_tx4_d;
      s0_ty4_q   <= s0_ty4_d;
      s0_p_q     <= s0_p_d;
      s1_v_q     <= s1_v_d;
      s1_tx4_q   <= s1_tx4_d;
      s1_ty4_q   <= s1_ty4_d;
      s1_p_q     <= s1_p_d;
      map_addr_q <= map_addr_d;
      map_rd_q   <= map_rd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= {s1_p_q, colour_s};
    end
  end

  // Head is masked when empty so the outputs read zero after reset.
  assign bus.in_ready  = in_ready_s;
  assign bus.map_addr  = map_addr_q;
  assign bus.map_rd    = map_rd_q;
  assign bus.out_valid = out_valid_s;
  assign bus.out_p     = out_valid_s ? head_s[21:12] : 10'd0;
  assign bus.out_color = out_valid_s ? head_s[11:0]  : 12'd0;
  assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_ground_texel_fetch.sv
// Scoreboard bench for ground_texel_fetch: stimulus pushes expected
// {p, colour} into a queue, a negedge monitor pops and compares each output.
module tb_ground_texel_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ground_texel_fetch_if bus();
  ground_texel_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  logic [21:0] expq[$];
  logic [21:0] mon_e;
  logic [3:0]  mem [0:127];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // synchronous map memory: data valid the cycle after map_rd
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.map_data <= 4'h0;
    else if (bus.map_rd) bus.map_data <= mem[bus.map_addr];
  end

  // monitor: compare every transferred texel against the scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      pops++;
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got p=%0d color=%h expected none", bus.out_p, bus.out_color);
      end else begin
        mon_e = expq.pop_front();
        check("out_p", {22'd0, bus.out_p}, {22'd0, mon_e[21:12]});
        check("out_color", {20'd0, bus.out_color}, {20'd0, mon_e[11:0]});
      end
    end
  end

  function automatic logic [11:0] model_color(input logic [9:0] x, input logic [9:0] y);
    logic [6:0] a;
    logic [3:0] d;
    a = 7'(y[8:5]) * 7'd11 + 7'(x[8:5]);
    d = mem[a];
    if (d == 4'h0) return (x[4] ^ y[4]) ? 12'hAAA : 12'h777;
    else if (d == 4'hF) return 12'h0F0;
    else return 12'h642;
  endfunction

  // drive one sample, waiting (bounded) for in_ready; returns at edge+1
  task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [9:0] p,
                      input logic [11:0] c, input bit ok);
    int n;
    n = 0;
    bus.in_x = x; bus.in_y = y; bus.in_p = p; bus.in_en = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready=0 expected 1");
      bus.in_en = 1'b0;
      return;
    end
    @(posedge clk);
    if (ok) expq.push_back({p, c});
    #1;
    bus.in_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(posedge clk);
    while (expq.size() != 0 && n < 300) begin
      @(posedge clk); n++;
    end
    #1;
    check("drain_empty", expq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int p0;
    bit held;
    logic [9:0] x, y;
    for (int i = 0; i < 128; i++) mem[i] = 4'h0;
    mem[120] = 4'hF; mem[12] = 4'h3; mem[2] = 4'h7; mem[60] = 4'hF; mem[33] = 4'h1;
    bus.in_x = 10'd0; bus.in_y = 10'd0; bus.in_z = 10'd0; bus.in_p = 10'd0;
    bus.in_en = 1'b0; bus.out_ready = 1'b1;

    // reset values
    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_map_rd", bus.map_rd, 0);
    check("rst_map_addr", bus.map_addr, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_p", {22'd0, bus.out_p}, 0);
    check("rst_out_color", bus.out_color, 0);
    check("rst_drop_cnt", bus.drop_cnt, 0);
    #19 rst_n = 1'b1;      // t=22, mid-cycle
    #1 check("ready_before_clk", bus.in_ready, 0);
    @(posedge clk); #1;
    check("ready_after_clk", bus.in_ready, 1);

    // first sample: latency and address
    send(10'd0, 10'd0, 10'd5, 12'h777, 1'b1);
    check("t1_map_rd", bus.map_rd, 1);
    check("t1_map_addr", bus.map_addr, 0);
    @(posedge clk); #1;
    check("t1_valid_c2", bus.out_valid, 0);
    @(posedge clk); #1;
    check("t1_valid_c3", bus.out_valid, 1);

    // checker, exit, wall and out-of-range samples
    send(10'd48, 10'd16, 10'd7, 12'h777, 1'b1);
    check("t2_map_addr", bus.map_addr, 1);
    send(10'd48, 10'd0, 10'd8, 12'hAAA, 1'b1);
    send(10'd320, 10'd320, 10'd9, 12'h0F0, 1'b1);
    check("t3_map_addr", bus.map_addr, 120);
    check("t3_map_rd", bus.map_rd, 1);
    send(10'd32, 10'd32, 10'd10, 12'h642, 1'b1);
    check("wall_map_addr", bus.map_addr, 12);
    send(10'd321, 10'd0, 10'd11, 12'h000, 1'b0);
    check("drop1_map_rd", bus.map_rd, 0);
    check("drop1_cnt", bus.drop_cnt, 1);
    send(10'h3FF, 10'd5, 10'd12, 12'h000, 1'b0);
    check("drop2_map_rd", bus.map_rd, 0);
    check("drop2_cnt", bus.drop_cnt, 2);
    drain();

    // backpressure: 8 back-to-back with out_ready low
    bus.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      x = 10'(i * 40); y = 10'(i * 16);
      bus.in_x = x; bus.in_y = y; bus.in_p = 10'(20 + i); bus.in_en = 1'b1;
      held = bus.in_ready;
      @(posedge clk);
      if (held) begin
        acc++;
        expq.push_back({10'(20 + i), model_color(x, y)});
      end
      #1;
    end
    bus.in_en = 1'b0;
    check("bp_accepted", acc, 4);
    check("bp_ready_low", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    for (int i = 4; i < 8; i++) begin
      x = 10'(i * 40); y = 10'(i * 16);
      send(x, y, 10'(20 + i), model_color(x, y), 1'b1);
    end
    drain();

    // full throughput: 100 samples, one per cycle
    p0 = pops;
    held = 1'b1;
    for (int i = 0; i < 100; i++) begin
      x = 10'((i * 37) % 321); y = 10'((i * 53) % 321);
      bus.in_x = x; bus.in_y = y; bus.in_p = 10'(i); bus.in_en = 1'b1;
      if (!bus.in_ready) held = 1'b0;
      @(posedge clk);
      if (bus.in_en) expq.push_back({10'(i), model_color(x, y)});
      #1;
    end
    bus.in_en = 1'b0;
    check("stream_ready_held", held, 1);
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    check("stream_outputs", pops - p0, 100);
    drain();

    // reset with samples in flight and in the FIFO
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_x = 10'(i * 64); bus.in_y = 10'd100; bus.in_p = 10'(40 + i); bus.in_en = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_en = 1'b0;
    check("pre_rst_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_drop_cnt", bus.drop_cnt, 0);
    check("post_rst_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    p0 = pops;
    repeat (10) @(posedge clk);
    #1;
    check("no_stale_outputs", pops - p0, 0);
    send(10'd32, 10'd32, 10'd33, 12'h642, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
